div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in EX, directly downstream of the register-file read stage. Consumes forwarded rs1/rs2 operand values and stalls the pipeline while iterating.
- Returns the result plus destination register index to the EX/MEM path.

Parameters:
- XLEN, 32, operand and result width; iteration counter is $clog2(XLEN)+1 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous kill (branch/trap); aborts any operation.
- start  input  1  request a divide; sampled only in IDLE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- rs1_val  input  XLEN  dividend.
- rs2_val  input  XLEN  divisor.
- rd_in  input  5  destination register index.
- busy  output  1  state != IDLE.
- stall  output  1  combinational: (IDLE & start & ~flush) | CALC | FIX.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient (op[1]=0) or remainder (op[1]=1); held until next accepted start.
- rd_out  output  5  rd_in captured at start; held with result.

Behaviour:
- Reset: state IDLE. busy, stall-internal regs, done, result, rd_out, counter all 0. Reset mid-operation aborts immediately; no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0 at edge E0:
  - Capture op and rd_in.
  - Signed ops (op[0]=0): record sign_q = s1^s2 and sign_r = s1. Load absolute values of operands.
  - Unsigned ops: sign flags 0, operands loaded raw.
- Special cases at E0 go straight to DONE; result written at E0; done high in the cycle after E0 (latency 1):
  - Divisor 0: quotient = all ones; remainder = rs1_val unchanged.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, op[0]=0): quotient = 0x80000000; remainder = 0.
- Otherwise at E0: go to CALC with counter=0.
- CALC: one step per edge.
  - Shift {rem(XLEN+1 bits), quo} left 1.
  - trial = rem - divisor.
  - If trial is non-negative: rem = trial, quo[0] = 1.
  - Counter increments each step; after the XLEN-th step (E32 for XLEN=32) go to FIX.
- FIX (edge E33):
  - result = op[1] ? (sign_r ? -rem : rem) : (sign_q ? -quo : quo), truncated to XLEN.
  - rd_out loaded; go to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Normal latency: start in cycle 0, done high in cycle 34 (XLEN+2).
- stall is low in the DONE cycle, so the pipeline advances and consumes result in that cycle.
- start while busy (CALC/FIX/DONE): ignored; no queueing. The pipeline holds start high under stall and re-presents it.
- start in DONE cycle: ignored. Re-presentation is accepted the following IDLE cycle; back-to-back issue rate is one op per 35 cycles.
- flush:
  - From any state, go to IDLE at next edge; done never asserts for the killed op.
  - flush and start both high in IDLE: flush wins, nothing accepted.
  - flush in the DONE cycle: done still pulses that cycle (already committed); state returns to IDLE.
- result/rd_out are not cleared by flush; they retain the last completed values.
- Remainder sign: follows the dividend. Quotient sign: XOR of operand signs. Both are truncating division per RISC-V spec.

Test Plan:
- DIV 20 / -3 (0x14, 0xFFFFFFFD), rd_in=5 -> stall high cycles 0..33; done in cycle 34 with result 0xFFFFFFFA, rd_out=5. Same operands with REM -> 0x00000002.
- REM -20 / 3 -> 0xFFFFFFFE. DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF. REMU 0xFFFFFFFF / 2 -> 0x00000001. Each completes with done in cycle 34.
- Divide-by-zero: DIV 7/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234. done in cycle 1 and stall high only in cycle 0. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both with latency 1.
- Flush mid-op: start at cycle 0, flush at cycle 10 -> busy=0 from cycle 11, done never pulses, result unchanged. Then start DIVU 100/7 at cycle 12 -> done in cycle 46 with result 14.
- Async reset asserted at cycle 20 of an operation -> busy, done, result, rd_out read 0 immediately. After release, start DIV 9/3 -> 3 with normal latency.
- Protocol: start held high through a whole op -> exactly one done pulse per 35 cycles. flush+start together in IDLE -> busy stays 0. flush in the DONE cycle -> done=1 that cycle, IDLE next.

Source files
------------

// File: rtl/div_unit_if.sv
// Issue/result bundle between the EX stage and the iterative divider.
// master = pipeline side, slave = divider side.
interface div_unit_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [4:0]      rd_in;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output flush, start, op, rs1_val, rs2_val, rd_in,
      input  busy, stall, done, result, rd_out
   );

   modport slave (
      input  flush, start, op, rs1_val, rs2_val, rd_in,
      output busy, stall, done, result, rd_out
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Iterates on operand magnitudes and applies the signs in a final FIX step.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          r_state, w_next;
   logic [1:0]      r_op;
   logic [4:0]      r_rd;
   logic            r_sign_q, r_sign_r;
   logic [XLEN-1:0] r_rem, r_quo, r_div;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_result;
   logic [4:0]      r_rd_out;

   logic            w_accept, w_signed, w_div0, w_ovf, w_special, w_last;
   logic [XLEN-1:0] w_abs1, w_abs2, w_spec_res, w_fix_res, w_diff, w_quo_sh;
   logic [XLEN:0]   w_sh;
   logic            w_ge;

   assign w_accept = (r_state == IDLE) && bus.start && !bus.flush;
   assign w_signed = !bus.op[0];
   assign w_div0   = (bus.rs2_val == '0);
   assign w_ovf    = w_signed && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.rs2_val == '1);
   assign w_special = w_div0 || w_ovf;
   assign w_abs1   = (w_signed && bus.rs1_val[XLEN-1]) ? -bus.rs1_val : bus.rs1_val;
   assign w_abs2   = (w_signed && bus.rs2_val[XLEN-1]) ? -bus.rs2_val : bus.rs2_val;

   // Divide-by-zero returns the raw dividend as remainder; overflow yields MIN / 0.
   always_comb begin
      w_spec_res = '0;
      if (w_div0)
         w_spec_res = bus.op[1] ? bus.rs1_val : '1;
      else
         w_spec_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // Remainder never reaches the divisor, so the XLEN-bit difference is exact when w_ge.
   assign w_sh     = {r_rem, r_quo[XLEN-1]};
   assign w_quo_sh = {r_quo[XLEN-2:0], 1'b0};
   assign w_ge     = (w_sh >= {1'b0, r_div});
   assign w_diff   = w_sh[XLEN-1:0] - r_div;
   assign w_last   = (r_cnt == CW'(XLEN-1));

   assign w_fix_res = r_op[1] ? (r_sign_r ? -r_rem : r_rem)
                              : (r_sign_q ? -r_quo : r_quo);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_next = w_special ? DONE : CALC;
         CALC: if (w_last)   w_next = FIX;
         FIX:                w_next = DONE;
         DONE:               w_next = IDLE;
         default:            w_next = IDLE;
      endcase
      if (bus.flush) w_next = IDLE;
   end

   always_comb begin
      bus.busy  = (r_state != IDLE);
      bus.stall = ((r_state == IDLE) && bus.start && !bus.flush) ||
                  (r_state == CALC) || (r_state == FIX);
      bus.done  = (r_state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op     <= '0;
         r_rd     <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else begin
         unique case (r_state)
            IDLE: if (w_accept) begin
               r_op     <= bus.op;
               r_rd     <= bus.rd_in;
               r_sign_q <= w_signed && (bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1]);
               r_sign_r <= w_signed && bus.rs1_val[XLEN-1];
               r_rem    <= '0;
               r_quo    <= w_abs1;
               r_div    <= w_abs2;
               r_cnt    <= '0;
               if (w_special) begin
                  r_result <= w_spec_res;
                  r_rd_out <= bus.rd_in;
               end
            end
            CALC: begin
               r_rem <= w_ge ? w_diff : w_sh[XLEN-1:0];
               r_quo <= {w_quo_sh[XLEN-1:1], w_ge};
               r_cnt <= r_cnt + 1'b1;
            end
            FIX: if (!bus.flush) begin
               r_result <= w_fix_res;
               r_rd_out <= r_rd;
            end
            default: ;
         endcase
      end
   end

   assign bus.result = r_result;
   assign bus.rd_out = r_rd_out;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: issue tasks push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_unit;
   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   div_unit_if #(.XLEN(32)) bus ();
   div_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   logic stall_h [0:4095];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (cyc < 4096) stall_h[cyc] <= bus.stall;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL spurious_done: done with no op outstanding (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("rd_out", {27'b0, bus.rd_out}, {27'b0, e.rd});
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic to_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit push, input logic [31:0] e_res,
                        input int lat, output int t0);
      @(posedge clk);
      #1;
      bus.start   = 1'b1;
      bus.op      = op;
      bus.rs1_val = a;
      bus.rs2_val = b;
      bus.rd_in   = rd;
      t0 = cyc;
      if (push) sb.push_back('{res: e_res, rd: rd, cyc: cyc + lat});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         n_err++;
         $display("FAIL wait_idle: timeout with %0d ops outstanding", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0, t1, bad;
      bus.start = 0; bus.flush = 0; bus.op = 0;
      bus.rs1_val = 0; bus.rs2_val = 0; bus.rd_in = 0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy",   bus.busy, 0);
      chk("rst_done",   bus.done, 0);
      chk("rst_stall",  bus.stall, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_rd_out", {27'b0, bus.rd_out}, 0);
      @(posedge clk); #1; rst = 1'b0;

      // DIV 20 / -3 with stall profile
      issue(DIV, 32'd20, 32'hFFFF_FFFD, 5'd5, 1, 32'hFFFF_FFFA, 34, t0);
      wait_idle();
      bad = 0;
      for (int k = 0; k <= 33; k++) if (stall_h[t0 + k] !== 1'b1) bad++;
      chk("stall_window_bad_cycles", bad, 0);
      chk("stall_low_in_done", stall_h[t0 + 34], 0);

      issue(REM,  32'd20,        32'hFFFF_FFFD, 5'd6, 1, 32'h0000_0002, 34, t0); wait_idle();
      issue(REM,  32'hFFFF_FFEC, 32'd3,         5'd7, 1, 32'hFFFF_FFFE, 34, t0); wait_idle();
      issue(DIVU, 32'hFFFF_FFFF, 32'd2,         5'd8, 1, 32'h7FFF_FFFF, 34, t0); wait_idle();
      issue(REMU, 32'hFFFF_FFFF, 32'd2,         5'd9, 1, 32'h0000_0001, 34, t0); wait_idle();

      // special cases, latency 1
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1, 32'h8000_0000, 1, t0); wait_idle();
      issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1, 32'h0000_0000, 1, t0); wait_idle();
      issue(DIV, 32'd7, 32'd0, 5'd2, 1, 32'hFFFF_FFFF, 1, t0);
      wait_idle();
      chk("div0_stall_c0", stall_h[t0], 1);
      chk("div0_stall_c1", stall_h[t0 + 1], 0);
      issue(REMU, 32'h1234, 32'd0, 5'd9, 1, 32'h0000_1234, 1, t0); wait_idle();

      // flush mid-op, then a fresh op
      issue(DIV, 32'd1000, 32'd3, 5'd11, 0, 0, 0, t0);
      to_cycle(t0 + 10);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("flush_busy", bus.busy, 0);
      chk("flush_result_kept", bus.result, 32'h0000_1234);
      chk("flush_rd_kept", {27'b0, bus.rd_out}, 32'd9);
      issue(DIVU, 32'd100, 32'd7, 5'd12, 1, 32'd14, 34, t1);
      chk("reissue_cycle", t1, t0 + 12);
      to_cycle(t0 + 41);
      chk("killed_op_no_write", bus.result, 32'h0000_1234);
      wait_idle();

      // async reset mid-op
      issue(DIV, 32'd1000, 32'd7, 5'd13, 0, 0, 0, t0);
      to_cycle(t0 + 20);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",   bus.busy, 0);
      chk("arst_done",   bus.done, 0);
      chk("arst_result", bus.result, 0);
      chk("arst_rd_out", {27'b0, bus.rd_out}, 0);
      @(posedge clk); #1; rst = 1'b0;
      issue(DIV, 32'd9, 32'd3, 5'd14, 1, 32'd3, 34, t0); wait_idle();

      // start held high across two ops
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = DIVU; bus.rs1_val = 32'd50; bus.rs2_val = 32'd5; bus.rd_in = 5'd7;
      t0 = cyc;
      sb.push_back('{res: 32'd10, rd: 5'd7, cyc: t0 + 34});
      sb.push_back('{res: 32'd10, rd: 5'd7, cyc: t0 + 69});
      to_cycle(t0 + 36);
      bus.start = 1'b0;
      wait_idle();
      chk("held_stall_in_done", stall_h[t0 + 34], 0);
      chk("held_stall_reaccept", stall_h[t0 + 35], 1);

      // flush and start together in IDLE
      @(posedge clk); #1;
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = DIV; bus.rs1_val = 32'd5; bus.rs2_val = 32'd1;
      #3 chk("flush_start_stall", bus.stall, 0);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_start_busy", bus.busy, 0);

      // flush in the DONE cycle
      issue(DIVU, 32'd9, 32'd2, 5'd15, 1, 32'd4, 34, t0);
      to_cycle(t0 + 34);
      bus.flush = 1'b1;
      #2 chk("flush_in_done_done", bus.done, 1);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("flush_in_done_idle", bus.busy, 0);
      chk("flush_in_done_result", bus.result, 32'd4);
      wait_idle();

      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
